// File: rtl/lif_neuron_accum.sv
// Leaky integrate-and-fire neuron stage.
//
// Each timestep takes N_SYN signed Q1.7 weight beats. Every beat is tagged with
// a presynaptic spike bit. The weights of spiking beats are added into a
// saturating membrane potential. A one-cycle arithmetic-shift leak follows,
// then a signed threshold compare. On a fire the potential resets to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any timestep in flight)
//   start_i    begin a timestep; only sampled while idle
//   w_valid_i  weight beat valid
//   w_ready_o  weight beat ready (high only while accumulating)
//   w_data_i   signed weight, Q1.7
//   spk_i      presynaptic spike qualifying w_data_i
//   vmem_o     registered signed membrane potential
//   spike_o    one-cycle output spike
//   done_o     one-cycle timestep-complete pulse
//   busy_o     high from start acceptance until return to idle
//   sat_o      sticky saturation flag, cleared on the next start
module lif_neuron_accum #(
    parameter int INP_WIDTH  = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int N_SYN      = 125,
    parameter int THRESHOLD  = 128,
    parameter int LEAK_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic [INP_WIDTH-1:0] w_data_i,
    input  logic                 spk_i,
    output logic [ACC_WIDTH-1:0] vmem_o,
    output logic                 spike_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 sat_o
);

    localparam int CNT_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_SYN - 1);

    // Clamp bounds, held one bit wider than the accumulator to match the sum.
    localparam logic signed [ACC_WIDTH:0] VMAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] VMIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] THR = ACC_WIDTH'(THRESHOLD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_LEAK,
        S_FIRE
    } state_e;

    state_e                        state_q, state_d;
    logic        [CNT_W-1:0]       cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]   vmem_q, vmem_d;
    logic                          spike_q, spike_d;
    logic                          done_q, done_d;
    logic                          busy_q, busy_d;
    logic                          ready_q, ready_d;
    logic                          sat_q, sat_d;

    logic signed [ACC_WIDTH:0]     sum;
    logic signed [ACC_WIDTH-1:0]   leaked;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vmem_q  <= '0;
            spike_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vmem_q  <= vmem_d;
            spike_q <= spike_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vmem_d  = vmem_q;
        spike_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;
        sat_d   = sat_q;

        // One guard bit makes overflow visible as a value outside [VMIN, VMAX].
        sum    = {vmem_q[ACC_WIDTH-1], vmem_q}
               + {{(ACC_WIDTH-INP_WIDTH+1){w_data_i[INP_WIDTH-1]}}, w_data_i};
        // v - (v >>> s) keeps the sign and shrinks the magnitude, so it cannot overflow.
        leaked = vmem_q - (vmem_q >>> LEAK_SHIFT);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ACCUM;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                    sat_d   = 1'b0;
                end
            end
            S_ACCUM: begin
                if (w_valid_i && ready_q) begin
                    if (spk_i) begin
                        if (sum > VMAX) begin
                            vmem_d = VMAX[ACC_WIDTH-1:0];
                            sat_d  = 1'b1;
                        end else if (sum < VMIN) begin
                            vmem_d = VMIN[ACC_WIDTH-1:0];
                            sat_d  = 1'b1;
                        end else begin
                            vmem_d = sum[ACC_WIDTH-1:0];
                        end
                    end
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_LEAK;
                        ready_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LEAK: begin
                if (LEAK_SHIFT > 0) begin
                    vmem_d = leaked;
                end
                state_d = S_FIRE;
            end
            S_FIRE: begin
                if (vmem_q >= THR) begin
                    spike_d = 1'b1;
                    vmem_d  = '0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_ready_o = ready_q;
    assign vmem_o    = vmem_q;
    assign spike_o   = spike_q;
    assign done_o    = done_q;
    assign busy_o    = busy_q;
    assign sat_o     = sat_q;

endmodule

// File: tb/tb_lif_neuron_accum.sv
module tb_lif_neuron_accum;

    logic        clk;
    logic        rst;
    logic        start   [3];
    logic        wv      [3];
    logic        spk     [3];
    logic [7:0]  wd      [3];
    logic        wr      [3];
    logic        spike   [3];
    logic        done    [3];
    logic        busy    [3];
    logic        sat     [3];
    logic [15:0] vm0;
    logic [15:0] vm1;
    logic [9:0]  vm2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int acc;
        int v;
        int spk;
        int sat;
    } exp_t;

    exp_t exp_q[$];
    int   model_v[3];

    // Instance 0: N_SYN=4, no leak
    lif_neuron_accum #(.INP_WIDTH(8), .ACC_WIDTH(16), .N_SYN(4), .THRESHOLD(128), .LEAK_SHIFT(0)) u0 (
        .clk(clk), .rst(rst), .start_i(start[0]), .w_valid_i(wv[0]), .w_ready_o(wr[0]),
        .w_data_i(wd[0]), .spk_i(spk[0]), .vmem_o(vm0), .spike_o(spike[0]),
        .done_o(done[0]), .busy_o(busy[0]), .sat_o(sat[0]));

    // Instance 1: N_SYN=3, leak shift 2
    lif_neuron_accum #(.INP_WIDTH(8), .ACC_WIDTH(16), .N_SYN(3), .THRESHOLD(128), .LEAK_SHIFT(2)) u1 (
        .clk(clk), .rst(rst), .start_i(start[1]), .w_valid_i(wv[1]), .w_ready_o(wr[1]),
        .w_data_i(wd[1]), .spk_i(spk[1]), .vmem_o(vm1), .spike_o(spike[1]),
        .done_o(done[1]), .busy_o(busy[1]), .sat_o(sat[1]));

    // Instance 2: N_SYN=5, 10-bit accumulator, leak shift 2
    lif_neuron_accum #(.INP_WIDTH(8), .ACC_WIDTH(10), .N_SYN(5), .THRESHOLD(128), .LEAK_SHIFT(2)) u2 (
        .clk(clk), .rst(rst), .start_i(start[2]), .w_valid_i(wv[2]), .w_ready_o(wr[2]),
        .w_data_i(wd[2]), .spk_i(spk[2]), .vmem_o(vm2), .spike_o(spike[2]),
        .done_o(done[2]), .busy_o(busy[2]), .sat_o(sat[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int vm(input int id);
        case (id)
            0:       return int'($signed(vm0));
            1:       return int'($signed(vm1));
            default: return int'($signed(vm2));
        endcase
    endfunction

    function automatic int b2i(input logic b);
        return (b === 1'b1) ? 1 : ((b === 1'b0) ? 0 : -1);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one timestep into instance id and scoreboards its result.
    task automatic run_ts(input int id, input logic [7:0] w[5], input bit s[5],
                          input bit gaps, input bit skip_start, input bit b2b_next);
        int   n, aw, ls, vmax, vmin, v, edges;
        bit   st;
        exp_t e;
        n  = (id == 0) ? 4 : ((id == 1) ? 3 : 5);
        aw = (id == 2) ? 10 : 16;
        ls = (id == 0) ? 0 : 2;
        vmax = (1 << (aw - 1)) - 1;
        vmin = -(1 << (aw - 1));
        v  = model_v[id];
        st = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (s[i]) begin
                v = v + int'($signed(w[i]));
                if (v > vmax) begin v = vmax; st = 1'b1; end
                if (v < vmin) begin v = vmin; st = 1'b1; end
            end
        end
        e.acc = v;
        if (ls > 0) v = v - (v >>> ls);
        e.spk = (v >= 128) ? 1 : 0;
        if (e.spk == 1) v = 0;
        e.v   = v;
        e.sat = int'(st);
        model_v[id] = v;
        exp_q.push_back(e);

        if (!skip_start) begin
            @(negedge clk); start[id] = 1'b1;
            @(negedge clk); start[id] = 1'b0;
        end
        check("busy_after_start", b2i(busy[id]), 1);
        check("ready_in_accum", b2i(wr[id]), 1);
        check("sat_cleared_on_start", b2i(sat[id]), 0);

        for (int b = 0; b < n; b++) begin
            if (gaps) begin
                wv[id] = 1'b0; start[id] = 1'b1;
                @(negedge clk); start[id] = 1'b0;
                @(negedge clk);
            end
            wv[id] = 1'b1; wd[id] = w[b]; spk[id] = s[b];
            @(negedge clk);
            if (b == n - 2) check("ready_before_last", b2i(wr[id]), 1);
        end
        wv[id] = 1'b0; spk[id] = 1'b0;

        e = exp_q.pop_front();
        check("vmem_after_accum", vm(id), e.acc);
        check("ready_drop", b2i(wr[id]), 0);
        check("no_early_done", b2i(done[id]), 0);

        edges = 0;
        while (done[id] !== 1'b1 && edges < 6) begin
            @(negedge clk);
            edges++;
        end
        check("done_latency", edges, 2);
        check("done_pulse", b2i(done[id]), 1);
        check("spike", b2i(spike[id]), e.spk);
        check("vmem_final", vm(id), e.v);
        check("sat", b2i(sat[id]), e.sat);
        check("busy_low_in_done", b2i(busy[id]), 0);
        if (b2b_next) start[id] = 1'b1;

        @(negedge clk);
        start[id] = 1'b0;
        check("done_one_cycle", b2i(done[id]), 0);
        check("spike_one_cycle", b2i(spike[id]), 0);
        if (b2b_next) begin
            check("b2b_busy", b2i(busy[id]), 1);
            check("b2b_sat_cleared", b2i(sat[id]), 0);
        end else begin
            check("idle_busy", b2i(busy[id]), 0);
            check("idle_ready", b2i(wr[id]), 0);
        end
    endtask

    task automatic check_reset_state(input int id);
        check("rst_vmem", vm(id), 0);
        check("rst_busy", b2i(busy[id]), 0);
        check("rst_ready", b2i(wr[id]), 0);
        check("rst_sat", b2i(sat[id]), 0);
        check("rst_spike", b2i(spike[id]), 0);
        check("rst_done", b2i(done[id]), 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; wv[i] = 1'b0; spk[i] = 1'b0; wd[i] = 8'h00;
            model_v[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset_state(i);

        // Fire without leak: 3 x 0.5 = 192, spike, reset to zero
        run_ts(0, '{8'h40, 8'h40, 8'h40, 8'h40, 8'h00}, '{1, 1, 0, 1, 0}, 0, 0, 0);
        check("fire_vmem_zero", vm(0), 0);

        // Backpressure with ignored start pulses during accumulation
        run_ts(0, '{8'h30, 8'hF0, 8'h10, 8'h05, 8'h00}, '{1, 1, 1, 0, 0}, 1, 0, 0);
        check("bp_vmem", vm(0), 48);

        // Leak carry-over across two timesteps
        run_ts(1, '{8'h20, 8'h20, 8'h20, 8'h00, 8'h00}, '{1, 1, 1, 0, 0}, 0, 0, 0);
        check("leak_ts1", vm(1), 72);
        run_ts(1, '{8'h20, 8'h20, 8'h20, 8'h00, 8'h00}, '{1, 1, 1, 0, 0}, 0, 0, 0);
        check("leak_ts2", vm(1), 126);

        // Positive saturation then back-to-back negative saturation
        run_ts(2, '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F}, '{1, 1, 1, 1, 1}, 0, 0, 1);
        run_ts(2, '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80}, '{1, 1, 1, 1, 1}, 0, 1, 0);
        check("neg_sat_vmem", vm(2), -384);
        check("neg_sat_flag", b2i(sat[2]), 1);

        // Build a nonzero carried potential, then abort a timestep by reset
        run_ts(0, '{8'h10, 8'h10, 8'h10, 8'h10, 8'h00}, '{1, 1, 1, 1, 0}, 0, 0, 0);
        check("carry_vmem", vm(0), 112);
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wv[0] = 1'b1; wd[0] = 8'h40; spk[0] = 1'b1;
            @(negedge clk);
        end
        wv[0] = 1'b0; spk[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("no_done_after_abort", b2i(done[0]), 0);
        end
        for (int i = 0; i < 3; i++) model_v[i] = 0;

        // Cold-start timestep after the abort
        run_ts(0, '{8'h40, 8'h40, 8'h40, 8'h40, 8'h00}, '{1, 1, 0, 1, 0}, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lif_neuron_accum.md
Name: lif_neuron_accum

Overview:
Leaky integrate-and-fire neuron stage. It sits directly downstream of the signed Q-point weight adder and weight memory. Per timestep it consumes a stream of N_SYN signed Q1.7 weights, each tagged with the presynaptic spike bit, and integrates the spiking weights into a saturating membrane potential. It then applies shift-based leak, compares against the threshold, and emits a single-cycle output spike with reset-to-zero.

Parameters:
INP_WIDTH, 8, weight width; signed Q1.7, LSB = 2^-7
ACC_WIDTH, 16, membrane potential width; signed, 7 fractional bits
N_SYN, 125, synapse beats per timestep (>=1)
THRESHOLD, 128, signed fire threshold in LSBs (128 = 1.0)
LEAK_SHIFT, 0, leak = vmem >>> LEAK_SHIFT; 0 disables leak

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start_i  input  1  begin timestep; sampled only in IDLE
w_valid_i  input  1  weight beat valid
w_ready_o  output  1  weight beat ready
w_data_i  input  INP_WIDTH  signed weight
spk_i  input  1  presynaptic spike for this beat; qualifies w_data_i
vmem_o  output  ACC_WIDTH  signed membrane potential (registered)
spike_o  output  1  output spike, one-cycle pulse
done_o  output  1  timestep complete, one-cycle pulse
busy_o  output  1  high from start acceptance until return to IDLE
sat_o  output  1  sticky: saturation occurred this timestep

Behaviour:
- Reset: state IDLE; vmem_o=0, spike_o=0, done_o=0, busy_o=0, w_ready_o=0, sat_o=0, beat counter=0. Reset mid-timestep aborts it: no done_o, no spike_o, partial sum discarded.
- States: IDLE -> ACCUM -> LEAK -> FIRE -> IDLE. All outputs are registered.
- IDLE: w_ready_o=0. On start_i=1 the next state is ACCUM, with counter=0, busy_o=1, sat_o cleared. start_i outside IDLE is ignored. start_i is accepted in the IDLE cycle where done_o is high.
- ACCUM: w_ready_o=1. A beat transfers only on w_valid_i & w_ready_o. Gaps in w_valid_i stall the counter. On a transfer with spk_i=1: vmem <= sat(vmem + sext(w_data_i)). spk_i=0 leaves vmem unchanged but still counts the beat. The transfer with counter==N_SYN-1 moves the state to LEAK, and w_ready_o deasserts the next cycle.
- Saturation: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp sets sat_o, which holds until the next start.
- LEAK (1 cycle): if LEAK_SHIFT>0, vmem <= vmem - (vmem >>> LEAK_SHIFT) using an arithmetic shift. The result cannot overflow.
- FIRE (1 cycle): if vmem >= THRESHOLD (signed compare), spike_o<=1 and vmem<=0. Otherwise spike_o<=0 and vmem is held. done_o<=1, busy_o<=0, state<=IDLE.
- spike_o and done_o are high for exactly one cycle (the first IDLE cycle).
- Latency: if the last beat is accepted at edge k, done_o/spike_o are visible after edge k+2.
- vmem persists across timesteps when no spike occurs.

Test Plan:
- Fire, no leak: N_SYN=4, LEAK_SHIFT=0, weights 0x40 x4, spk 1,1,0,1 -> vmem 192 after ACCUM; spike_o=1, done_o=1 for one cycle, 2 edges after the last beat; vmem_o=0 afterwards.
- Leak carry-over: N_SYN=3, LEAK_SHIFT=2, weights 0x20 all spiking -> 96, leak to 72, no spike, vmem_o=72. Second timestep with identical input -> 168, leak to 126, no spike.
- Negative and saturation: N_SYN=5, ACC_WIDTH=10.
  - Weights 0x7F all spiking -> clamps at 511, sat_o=1, spike_o=1.
  - Next timestep, weights 0x80 x5 -> clamps at -512; with LEAK_SHIFT=2 leak gives -384; no spike; sat_o=1.
- Backpressure: w_valid_i toggled 1,0,0,1,... -> only handshaken beats are counted; exactly N_SYN transfers before LEAK; extra start_i pulses during ACCUM are ignored.
- Reset mid-ACCUM after 2 of 4 beats -> all outputs return to reset values and no done_o. A subsequent full timestep behaves as from cold.
- Back-to-back: start_i asserted in the done_o cycle -> new timestep accepted with no idle gap; sat_o cleared.
